// File: rtl/cgra_mem_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cgra_mem_tile_pkg
// Purpose  : Shared definitions for the CGRA memory tile: register indices,
//            CTRL bit positions, reset constants and the LFSR step function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cgra_mem_tile_pkg;

  // Register indices (config_addr_in[7:0])
  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_AF_THRESH = 8'h01;
  localparam logic [7:0] REG_SEED      = 8'h02;
  localparam logic [7:0] REG_STATUS    = 8'h03;

  // CTRL bit positions
  localparam int CTRL_WEN = 0;
  localparam int CTRL_REN = 1;
  localparam int CTRL_CLR = 2;

  // Reset constants
  localparam int          AF_GAP        = 8;       // AF_THRESH resets to DEPTH - AF_GAP
  localparam logic [15:0] LFSR_SEED_RST = 16'hACE1;

  typedef struct packed {
    logic clr;
    logic ren;
    logic wen;
  } ctrl_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11. In the right-shifting form
  // those taps land on state bits 0,2,3,5 and the feedback enters at bit 15.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage : cgra_mem_tile_pkg
`default_nettype wire

// File: rtl/mem_tile_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_tile_fifo
// Purpose  : 16-bit synchronous FIFO with registered read port and exact,
//            registered empty / full / almost-full flags.
// Ports    : clk_in, reset_in (async, active-low)
//            wen_i, ren_i, clr_i  - requests (clr wins over push/pop)
//            din_i                - push data
//            af_thresh_i          - almost-full threshold (next-state value)
//            push_o               - push accepted this cycle
//            dout_o, valid_o      - read data, one-cycle pulse per pop
//            count_o, empty_o, full_o, af_o - occupancy and flags
// Revision : 1.0 - initial release
// ============================================================================
module mem_tile_fifo #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          wen_i,
  input  logic          ren_i,
  input  logic          clr_i,
  input  logic [15:0]   din_i,
  input  logic [AW:0]   af_thresh_i,
  output logic          push_o,
  output logic [15:0]   dout_o,
  output logic          valid_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          af_o
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q, af_q, valid_q;
  logic [15:0]   dout_q;
  logic          push, pop;

  // Push and pop are gated independently by their own flag, so a
  // simultaneous request on a full FIFO degrades to pop-only and on an
  // empty FIFO to push-only.
  always_comb begin
    push    = wen_i && !full_q  && !clr_i;
    pop     = ren_i && !empty_q && !clr_i;
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      // Flags come from the next-state count so they never lag by a cycle.
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
      af_q    <= (count_d >= af_thresh_i);
      valid_q <= pop;
      if (pop) dout_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage array carries no reset so it can map onto SRAM. Read and write
  // pointers only coincide when empty or full, where one side is gated off.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

  assign push_o  = push;
  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign af_o    = af_q;

endmodule : mem_tile_fifo
`default_nettype wire

// File: rtl/cgra_mem_tile_top.sv
`default_nettype none
// ============================================================================
// Module   : cgra_mem_tile_top
// Purpose  : One CGRA memory tile: strobe-less config register file, LFSR
//            data source and a 16-bit FIFO, with combinational readback.
// Ports    : clk_in, reset_in (async, active-low)
//            config_addr_in [31:16] tile id, [15:8] reserved, [7:0] index
//            config_data_in write data
//            config_rdata   readback of addressed register (0 on mismatch)
//            dout, valid    FIFO read data and per-pop pulse
//            af, empty, full FIFO flags
// Revision : 1.0 - initial release
// ============================================================================
module cgra_mem_tile_top
  import cgra_mem_tile_pkg::*;
#(
  parameter logic [15:0] TILE_ID = 16'h0001,
  parameter int          DEPTH   = 512,
  parameter int          AW      = 9
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] config_addr_in,
  input  logic [31:0] config_data_in,
  output logic [31:0] config_rdata,
  output logic [15:0] dout,
  output logic        valid,
  output logic        af,
  output logic        empty,
  output logic        full
);

  localparam logic [AW:0] AF_RST = (AW+1)'(DEPTH - AF_GAP);

  ctrl_t       ctrl_q, ctrl_d;
  logic [AW:0] thresh_q, thresh_d;
  logic [15:0] seed_q, seed_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [AW:0] count;
  logic        push;
  logic        id_match, rsvd_ok, cfg_wr;
  logic [7:0]  idx;
  logic        unused_data;

  // Upper data bits have no register behind them.
  assign unused_data = ^config_data_in[31:16];

  assign id_match = (config_addr_in[31:16] == TILE_ID);
  assign rsvd_ok  = (config_addr_in[15:8] == 8'h00);
  assign idx      = config_addr_in[7:0];
  // No strobe: every edge with a matching, non-null address is a write.
  // A non-zero reserved field addresses no register.
  assign cfg_wr   = id_match && rsvd_ok && (config_addr_in != '0);

  always_comb begin
    ctrl_d     = ctrl_q;
    ctrl_d.clr = 1'b0;   // clr lives for exactly one cycle after its write
    thresh_d   = thresh_q;
    seed_d     = seed_q;
    lfsr_d     = push ? lfsr_next(lfsr_q) : lfsr_q;
    if (cfg_wr) begin
      case (idx)
        REG_CTRL: begin
          ctrl_d.wen = config_data_in[CTRL_WEN];
          ctrl_d.ren = config_data_in[CTRL_REN];
          ctrl_d.clr = config_data_in[CTRL_CLR];
        end
        REG_AF_THRESH: thresh_d = config_data_in[AW:0];
        REG_SEED: begin
          // Reseeding overrides a same-cycle LFSR advance.
          seed_d = config_data_in[15:0];
          lfsr_d = config_data_in[15:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ctrl_q   <= '0;
      thresh_q <= AF_RST;
      seed_q   <= LFSR_SEED_RST;
      lfsr_q   <= LFSR_SEED_RST;
    end else begin
      ctrl_q   <= ctrl_d;
      thresh_q <= thresh_d;
      seed_q   <= seed_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    config_rdata = '0;
    if (id_match && rsvd_ok) begin
      case (idx)
        REG_CTRL:      config_rdata = 32'(ctrl_q);
        REG_AF_THRESH: config_rdata = 32'(thresh_q);
        REG_SEED:      config_rdata = 32'(seed_q);
        REG_STATUS:    config_rdata = 32'({count, full, empty, af});
        default:       config_rdata = '0;
      endcase
    end
  end

  // The FIFO sees the next-state threshold so af stays exact across a
  // threshold write.
  mem_tile_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .wen_i       (ctrl_q.wen),
    .ren_i       (ctrl_q.ren),
    .clr_i       (ctrl_q.clr),
    .din_i       (lfsr_q),
    .af_thresh_i (thresh_d),
    .push_o      (push),
    .dout_o      (dout),
    .valid_o     (valid),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .af_o        (af)
  );

endmodule : cgra_mem_tile_top
`default_nettype wire

// File: tb/tb_cgra_mem_tile_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgra_mem_tile_top
// Purpose  : Self-checking bench for cgra_mem_tile_top: register table,
//            fill/drain/simultaneous/clear/reset sequences, random traffic
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_mem_tile_top;

  localparam int          DEPTH  = 512;
  localparam logic [15:0] TID    = 16'h0001;
  localparam logic [31:0] A_CTRL = {TID, 16'h0000};
  localparam logic [31:0] A_AF   = {TID, 16'h0001};
  localparam logic [31:0] A_SEED = {TID, 16'h0002};
  localparam logic [31:0] A_STAT = {TID, 16'h0003};

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [31:0] config_addr_in = '0;
  logic [31:0] config_data_in = '0;
  logic [31:0] config_rdata;
  logic [15:0] dout;
  logic        valid, af, empty, full;

  always #5 clk_in = ~clk_in;

  cgra_mem_tile_top #(.TILE_ID(TID), .DEPTH(DEPTH), .AW(9)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .config_addr_in (config_addr_in),
    .config_data_in (config_data_in),
    .config_rdata   (config_rdata),
    .dout           (dout),
    .valid          (valid),
    .af             (af),
    .empty          (empty),
    .full           (full)
  );

  int total = 0;
  int bad   = 0;
  int n_valid = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic        m_wen, m_ren, m_clr, m_valid;
  int          m_thresh;
  logic [15:0] m_seed, m_lfsr, m_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = ^(s & 16'h002D);
    return (s >> 1) | {fb, 15'b0};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wen = 0; m_ren = 0; m_clr = 0; m_valid = 0;
    m_thresh = DEPTH - 8;
    m_seed = 16'hACE1; m_lfsr = 16'hACE1; m_dout = 16'h0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [31:0] d);
    int  sz;
    bit  hit, do_pop, do_push;
    sz  = mq.size();
    hit = (a != 0) && (a[31:16] == TID) && (a[15:8] == 8'h00);
    if (m_clr) begin
      mq.delete();
      m_valid = 0;
    end else begin
      do_pop  = m_ren && (sz > 0);
      do_push = m_wen && (sz < DEPTH);
      if (do_pop) m_dout = mq.pop_front();
      m_valid = do_pop;
      if (do_push) begin
        mq.push_back(m_lfsr);
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
    m_clr = 0;
    if (hit) begin
      case (a[7:0])
        8'h00: begin m_wen = d[0]; m_ren = d[1]; m_clr = d[2]; end
        8'h01: m_thresh = int'(d[9:0]);
        8'h02: begin m_seed = d[15:0]; m_lfsr = d[15:0]; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    int sz;
    sz = mq.size();
    if (a[31:16] != TID || a[15:8] != 8'h00) return 32'h0;
    case (a[7:0])
      8'h00: return 32'(int'(m_wen) + 2 * int'(m_ren) + 4 * int'(m_clr));
      8'h01: return 32'(m_thresh);
      8'h02: return 32'(m_seed);
      8'h03: return 32'(sz * 8 + 4 * int'(sz == DEPTH) + 2 * int'(sz == 0)
                        + int'(sz >= m_thresh));
      default: return 32'h0;
    endcase
  endfunction

  // Called at a negedge: drive bus for one edge, then compare all outputs.
  task automatic tick(input logic [31:0] a, input logic [31:0] d);
    int sz;
    config_addr_in = a;
    config_data_in = d;
    @(posedge clk_in);
    model_edge(a, d);
    @(negedge clk_in);
    config_addr_in = '0;
    config_data_in = '0;
    sz = mq.size();
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full",  32'(full),  32'(sz == DEPTH));
    chk("af",    32'(af),    32'(sz >= m_thresh));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("dout",  32'(dout),  32'(m_dout));
    if (valid) n_valid++;
  endtask

  // Combinational readback; the address is removed before the next edge so
  // the peek never becomes a write.
  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    config_addr_in = a;
    #1;
    chk(nm, config_rdata, exp);
    config_addr_in = '0;
  endtask

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int af_at, full_at;
    logic [15:0] ref_v;
    logic [31:0] ra, da;
    int r;

    tbl[0]  = '{A_AF,   32'h0000_0100, A_AF,   32'h0000_0100, "tbl_af_100"};
    tbl[1]  = '{A_AF,   32'hFFFF_FFFF, A_AF,   32'h0000_03FF, "tbl_af_mask"};
    tbl[2]  = '{A_AF,   32'd504,       A_AF,   32'd504,       "tbl_af_restore"};
    tbl[3]  = '{A_SEED, 32'h1234_BEEF, A_SEED, 32'h0000_BEEF, "tbl_seed"};
    tbl[4]  = '{A_SEED, 32'h0000_ACE1, A_SEED, 32'h0000_ACE1, "tbl_seed_restore"};
    tbl[5]  = '{A_STAT, 32'hFFFF_FFFF, A_STAT, 32'h0000_0002, "tbl_status_ro"};
    tbl[6]  = '{{TID, 16'h0055}, 32'hFFFF, {TID, 16'h0055}, 32'h0, "tbl_unknown"};
    tbl[7]  = '{32'h0002_0001, 32'h10, A_AF, 32'd504, "tbl_foreign_af"};
    tbl[8]  = '{32'h0000_0000, 32'h7,  A_CTRL, 32'h0, "tbl_null_ctrl"};
    tbl[9]  = '{32'h0002_0000, 32'h3,  A_CTRL, 32'h0, "tbl_foreign_ctrl"};
    tbl[10] = '{32'h0000_0000, 32'h0,  32'h0002_0001, 32'h0, "tbl_foreign_read"};

    // Reset
    model_reset();
    repeat (8) @(negedge clk_in);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_af",    32'(af),    32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_dout",  32'(dout),  32'h0);
    peek("rst_af_thresh", A_AF, 32'(DEPTH - 8));
    reset_in = 1'b1;

    // Register table
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].wa, tbl[i].wd);
      peek(tbl[i].name, tbl[i].ra, tbl[i].exp);
    end

    // Fill
    tick(A_CTRL, 32'h1);
    af_at = -1; full_at = -1;
    for (int k = 1; k <= DEPTH + 8; k++) begin
      tick(32'h0, 32'h0);
      if (af && af_at < 0) af_at = k;
      if (full && full_at < 0) full_at = k;
    end
    chk("fill_af_rise", 32'(af_at), 32'd504);
    chk("fill_full_at", 32'(full_at), 32'd512);
    peek("fill_status", A_STAT, 32'h0000_1005);

    // Drain
    tick(A_CTRL, 32'h2);
    n_valid = 0;
    ref_v = 16'hACE1;
    for (int k = 0; k < DEPTH + 8; k++) begin
      tick(32'h0, 32'h0);
      if (valid) begin
        chk("drain_seq", 32'(dout), 32'(ref_v));
        ref_v = lfsr_step(ref_v);
      end
    end
    chk("drain_pulses", 32'(n_valid), 32'd512);
    chk("drain_empty", 32'(empty), 32'h1);

    // Simultaneous push+pop at count 10
    tick(A_CTRL, 32'h1);
    repeat (9) tick(32'h0, 32'h0);
    tick(A_CTRL, 32'h0);
    peek("sim_status10", A_STAT, 32'h0000_0050);
    tick(A_CTRL, 32'h3);
    n_valid = 0;
    repeat (20) tick(32'h0, 32'h0);
    chk("sim_pulses", 32'(n_valid), 32'd20);
    peek("sim_status_hold", A_STAT, 32'h0000_0050);

    // clr with wen/ren set: flush wins, then push-only on empty FIFO
    tick(A_CTRL, 32'h7);
    tick(32'h0, 32'h0);
    chk("clr_valid", 32'(valid), 32'h0);
    peek("clr_status", A_STAT, 32'h0000_0002);
    peek("clr_selfclear", A_CTRL, 32'h3);
    tick(32'h0, 32'h0);
    chk("sim_empty_valid", 32'(valid), 32'h0);
    peek("sim_empty_status", A_STAT, 32'h0000_0008);
    tick(A_CTRL, 32'h0);
    chk("sim_one_valid", 32'(valid), 32'h1);
    peek("sim_one_status", A_STAT, 32'h0000_0008);
    peek("sim_ctrl_off", A_CTRL, 32'h0);

    // Mid-operation reset at count 300
    tick(A_CTRL, 32'h5);          // clr + wen: flush, then fill
    repeat (300) tick(32'h0, 32'h0);
    tick(A_CTRL, 32'h0);
    peek("mid_status300", A_STAT, 32'h0000_0960);
    reset_in = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 32'h1);
    chk("mid_rst_af",    32'(af),    32'h0);
    chk("mid_rst_full",  32'(full),  32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    peek("mid_rst_status", A_STAT, 32'h0000_0002);
    model_reset();
    repeat (8) @(negedge clk_in);
    reset_in = 1'b1;

    // Random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      da = $urandom();
      case (r)
        4: begin
          ra = A_CTRL;
          da = 32'($urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) da = da | 32'h4;
        end
        5: begin ra = A_AF; da = 32'($urandom_range(0, 600)); end
        6: ra = A_SEED;
        7: ra = {16'($urandom_range(2, 65535)), 16'($urandom_range(0, 3))};
        8: ra = A_STAT;
        9: ra = {TID, 8'h00, 8'($urandom_range(4, 255))};
        default: ra = 32'h0;
      endcase
      tick(ra, da);
      if (k % 7 == 0) begin
        ra = {TID, (($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00), 8'($urandom_range(0, 4))};
        peek("rand_rdata", ra, model_rdata(ra));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cgra_mem_tile_top
`default_nettype wire
